// File: rtl/ie_defs.sv
// Shared definitions for the UART memory command controller:
// command opcodes and the controller state encoding.
package ie_defs;

   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_HALT  = 8'h06;
   localparam logic [7:0] CMD_RUN   = 8'h07;

   typedef enum logic [3:0] {
      StIdle,
      StGetAh,
      StGetAl,
      StGetData,
      StBusWr,
      StBusRd,
      StRdWait,
      StTxReq,
      StTxWait
   } state_e;

endpackage

// File: rtl/uart_mem_cmd_ctrl.sv
// UART command controller: parses WRITE/READ/HALT/RUN byte commands and, while the CPU
// is halted, takes over the shared memory bus to service them.
module uart_mem_cmd_ctrl
   import ie_defs::*;
#(
   parameter int unsigned MEM_RD_LAT = 1,
   parameter int unsigned RX_TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_active,
   input  logic        tx_done,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata,
   output logic        cpu_halt,
   output logic [15:0] sys_addr
);

   localparam int unsigned GapW = $clog2(RX_TIMEOUT + 1);
   localparam logic [GapW-1:0] GapMax  = GapW'(RX_TIMEOUT);
   localparam logic [GapW-1:0] GapLast = GapW'(RX_TIMEOUT - 1);
   localparam logic [7:0] LatLast = 8'(MEM_RD_LAT - 1);

   state_e          state_q;
   logic            is_wr_q;
   logic [15:0]     addr_q;
   logic [7:0]      data_q;
   logic [GapW-1:0] gap_q;
   logic [7:0]      lat_q;
   logic            in_get;
   logic            timeout;

   assign in_get  = state_q inside {StGetAh, StGetAl, StGetData};
   assign timeout = !rx_valid && (gap_q == GapLast);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         is_wr_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         gap_q    <= '0;
         lat_q    <= '0;
         cpu_halt <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= '0;
         sys_addr <= '0;
      end else begin
         tx_start <= 1'b0;

         // Byte-gap counter: cleared on each accepted byte, saturates instead of wrapping.
         if (!in_get || rx_valid) begin
            gap_q <= '0;
         end else if (gap_q != GapMax) begin
            gap_q <= gap_q + GapW'(1);
         end

         case (state_q)
            StIdle: begin
               if (rx_valid) begin
                  case (rx_data)
                     CMD_WRITE: begin
                        is_wr_q <= 1'b1;
                        state_q <= StGetAh;
                     end
                     CMD_READ: begin
                        is_wr_q <= 1'b0;
                        state_q <= StGetAh;
                     end
                     CMD_HALT: cpu_halt <= 1'b1;
                     CMD_RUN:  cpu_halt <= 1'b0;
                     default: ;
                  endcase
               end
            end
            StGetAh: begin
               if (rx_valid) begin
                  addr_q[15:8] <= rx_data;
                  state_q      <= StGetAl;
               end else if (timeout) begin
                  state_q <= StIdle;
               end
            end
            StGetAl: begin
               if (rx_valid) begin
                  addr_q[7:0] <= rx_data;
                  if (is_wr_q) begin
                     state_q <= StGetData;
                  end else if (cpu_halt) begin
                     state_q <= StBusRd;
                  end else begin
                     // CPU owns the bus: answer a read without touching memory.
                     tx_data <= 8'hFF;
                     state_q <= StTxReq;
                  end
               end else if (timeout) begin
                  state_q <= StIdle;
               end
            end
            StGetData: begin
               if (rx_valid) begin
                  data_q  <= rx_data;
                  state_q <= cpu_halt ? StBusWr : StIdle;
               end else if (timeout) begin
                  state_q <= StIdle;
               end
            end
            StBusWr: begin
               sys_addr <= addr_q;
               state_q  <= StIdle;
            end
            StBusRd: begin
               sys_addr <= addr_q;
               lat_q    <= '0;
               state_q  <= StRdWait;
            end
            StRdWait: begin
               if (lat_q == LatLast) begin
                  tx_data <= mem_rdata;
                  state_q <= StTxReq;
               end else begin
                  lat_q <= lat_q + 8'd1;
               end
            end
            StTxReq: begin
               if (!tx_active) begin
                  tx_start <= 1'b1;
                  state_q  <= StTxWait;
               end
            end
            StTxWait: begin
               if (tx_done) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mem_addr  = cpu_halt ? addr_q : cpu_addr;
   assign mem_wdata = cpu_halt ? data_q : cpu_wdata;
   assign mem_we    = cpu_halt ? (state_q == StBusWr) : cpu_we;
   assign mem_re    = cpu_halt && (state_q == StBusRd);
   assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_uart_mem_cmd_ctrl.sv
// Self-checking bench for uart_mem_cmd_ctrl: bus-mux vector table plus directed
// command sequences (write, read, run-mode, timeout, reset mid-read).
module tb_uart_mem_cmd_ctrl;
   import ie_defs::*;

   localparam int unsigned MemLat = 2;
   localparam int unsigned RxTo   = 20;

   logic        clk;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_active;
   logic        tx_done;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata;
   logic        cpu_halt;
   logic [15:0] sys_addr;

   uart_mem_cmd_ctrl #(
      .MEM_RD_LAT(MemLat),
      .RX_TIMEOUT(RxTo)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_active(tx_active),
      .tx_done  (tx_done),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_we   (cpu_we),
      .cpu_rdata(cpu_rdata),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we   (mem_we),
      .mem_re   (mem_re),
      .mem_rdata(mem_rdata),
      .cpu_halt (cpu_halt),
      .sys_addr (sys_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: read data appears exactly MemLat cycles after mem_re, else background.
   logic [1:0] re_pipe = 2'b00;
   logic [7:0] rd_value;
   logic [7:0] bg_rdata;
   always @(posedge clk) re_pipe <= {re_pipe[0], mem_re};
   assign mem_rdata = re_pipe[1] ? rd_value : bg_rdata;

   int          we_cnt = 0;
   logic [15:0] we_addr = '0;
   logic [7:0]  we_data = '0;
   int          re_cnt = 0;
   logic [15:0] re_addr = '0;
   int          txs_cnt = 0;
   logic [7:0]  txs_data = '0;

   // cpu_we is held low during commands, so any mem_we seen then is controller-issued.
   always @(negedge clk) begin
      if (rst && mem_we && !cpu_we) begin
         we_cnt  <= we_cnt + 1;
         we_addr <= mem_addr;
         we_data <= mem_wdata;
      end
      if (rst && mem_re) begin
         re_cnt  <= re_cnt + 1;
         re_addr <= mem_addr;
      end
      if (tx_start) begin
         txs_cnt  <= txs_cnt + 1;
         txs_data <= tx_data;
      end
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse_done();
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      #1;
   endtask

   task automatic wait_tx(input int prev, input string name);
      for (int i = 0; i < 100 && txs_cnt == prev; i++) @(negedge clk);
      #1;
      check(name, 32'(txs_cnt != prev), 32'd1);
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        we;
      logic [7:0]  rdata;
      logic [15:0] exp_addr;
      logic [7:0]  exp_wdata;
      logic        exp_we;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int prev_tx;
      vecs[0] = '{16'h0200, 8'h11, 1'b1, 8'h5A, 16'h0200, 8'h11, 1'b1};
      vecs[1] = '{16'hFFFF, 8'h00, 1'b0, 8'hA5, 16'hFFFF, 8'h00, 1'b0};
      vecs[2] = '{16'h1234, 8'hFF, 1'b1, 8'h00, 16'h1234, 8'hFF, 1'b1};
      vecs[3] = '{16'h8001, 8'h3C, 1'b0, 8'hC3, 16'h8001, 8'h3C, 1'b0};

      rst = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_active = 1'b0; tx_done = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; bg_rdata = '0; rd_value = '0;

      idle(3);
      check("reset cpu_halt", 32'(cpu_halt), 32'd0);
      check("reset tx_start", 32'(tx_start), 32'd0);
      check("reset tx_data", 32'(tx_data), 32'h00);
      check("reset sys_addr", 32'(sys_addr), 32'h0000);
      check("reset mem_re", 32'(mem_re), 32'd0);
      check("reset mem_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle(2);

      // CPU owns the bus: pure pass-through.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata; cpu_we = vecs[i].we;
         bg_rdata = vecs[i].rdata;
         #1;
         check("run mem_addr", 32'(mem_addr), 32'(vecs[i].exp_addr));
         check("run mem_wdata", 32'(mem_wdata), 32'(vecs[i].exp_wdata));
         check("run mem_we", 32'(mem_we), 32'(vecs[i].exp_we));
         check("run mem_re", 32'(mem_re), 32'd0);
         check("run cpu_rdata", 32'(cpu_rdata), 32'(vecs[i].rdata));
      end
      @(negedge clk);
      cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; bg_rdata = 8'h33;

      // Unknown opcode ignored, then HALT.
      send(8'h55);
      idle(2);
      check("0x55 ignored", 32'(cpu_halt), 32'd0);
      send(CMD_HALT);
      check("halt set", 32'(cpu_halt), 32'd1);

      // Halted WRITE.
      send(CMD_WRITE); send(8'h80); send(8'h00); send(8'hA5);
      idle(3);
      check("write we count", 32'(we_cnt), 32'd1);
      check("write addr", 32'(we_addr), 32'h8000);
      check("write data", 32'(we_data), 32'hA5);
      check("write sys_addr", 32'(sys_addr), 32'h8000);

      // Controller owns the bus: CPU inputs have no effect.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata; cpu_we = vecs[i].we;
         bg_rdata = vecs[i].rdata;
         #1;
         check("halt mem_addr", 32'(mem_addr), 32'h8000);
         check("halt mem_wdata", 32'(mem_wdata), 32'hA5);
         check("halt mem_we", 32'(mem_we), 32'd0);
         check("halt cpu_rdata", 32'(cpu_rdata), 32'(vecs[i].rdata));
      end
      @(negedge clk);
      cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; bg_rdata = 8'h33;

      // Halted READ with the transmitter busy at first.
      rd_value  = 8'h5C;
      tx_active = 1'b1;
      send(CMD_READ); send(8'h01); send(8'h23);
      idle(10);
      check("read re count", 32'(re_cnt), 32'd1);
      check("read addr", 32'(re_addr), 32'h0123);
      check("read sys_addr", 32'(sys_addr), 32'h0123);
      check("tx held while active", 32'(txs_cnt), 32'd0);
      check("read latched data", 32'(tx_data), 32'h5C);
      send(CMD_RUN);
      check("rx dropped in TX_REQ", 32'(cpu_halt), 32'd1);
      @(negedge clk);
      tx_active = 1'b0;
      wait_tx(0, "read tx_start seen");
      idle(3);
      check("read tx_start once", 32'(txs_cnt), 32'd1);
      check("read tx_data at start", 32'(txs_data), 32'h5C);
      send(CMD_RUN);
      check("rx dropped in TX_WAIT", 32'(cpu_halt), 32'd1);
      pulse_done();
      idle(2);

      // Run mode: READ answers 0xFF with no bus access, WRITE issues nothing.
      send(CMD_RUN);
      check("run cleared halt", 32'(cpu_halt), 32'd0);
      send(CMD_READ); send(8'h00); send(8'h00);
      wait_tx(1, "run read tx_start seen");
      idle(1);
      check("run read tx_data", 32'(txs_data), 32'hFF);
      check("run read no mem_re", 32'(re_cnt), 32'd1);
      pulse_done();
      send(CMD_WRITE); send(8'h12); send(8'h34); send(8'h56);
      idle(3);
      check("run write no mem_we", 32'(we_cnt), 32'd1);

      // Gap below the timeout is tolerated.
      send(CMD_HALT);
      send(CMD_WRITE);
      idle(15);
      send(8'h90); send(8'h00); send(8'h77);
      idle(3);
      check("slow write count", 32'(we_cnt), 32'd2);
      check("slow write addr", 32'(we_addr), 32'h9000);
      check("slow write data", 32'(we_data), 32'h77);

      // Gap beyond the timeout aborts; next byte is a fresh opcode.
      send(CMD_WRITE); send(8'h80);
      idle(RxTo + 5);
      send(CMD_RUN);
      idle(1);
      check("timeout then RUN", 32'(cpu_halt), 32'd0);
      check("timeout no write", 32'(we_cnt), 32'd2);

      // Reset while waiting on read data.
      send(CMD_HALT);
      send(CMD_READ); send(8'h01); send(8'h23);
      @(negedge clk);
      prev_tx = txs_cnt;
      rst = 1'b0;
      #1;
      check("mid reset cpu_halt", 32'(cpu_halt), 32'd0);
      check("mid reset tx_data", 32'(tx_data), 32'h00);
      check("mid reset sys_addr", 32'(sys_addr), 32'h0000);
      check("mid reset mem_re", 32'(mem_re), 32'd0);
      check("mid reset tx_start", 32'(tx_start), 32'd0);
      idle(3);
      @(negedge clk);
      rst = 1'b1;
      idle(30);
      check("no tx after reset", 32'(txs_cnt), 32'(prev_tx));
      check("tx_data stays reset", 32'(tx_data), 32'h00);
      check("no write after reset", 32'(we_cnt), 32'd2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

endmodule
